// File: rtl/frame_event_controller.sv
// Purpose : per-frame collision/pocket detection for two balls, ball show/blink/hide sequencing, score keeping.
// Latency : hit flags gathered over a frame; event pulses and score update one cycle after startOfFrame.
// Backpressure: none; purely frame-paced, all state frozen between startOfFrame pulses.
module frame_event_controller #(
    parameter int BLINK_FRAMES   = 8,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       drawingRequestHole,
    input  logic       drawingRequestWBall,
    input  logic       drawingRequestRBall,
    input  logic       drawingRequestBorders,
    output logic       wBallEnable,
    output logic       rBallEnable,
    output logic       wBallSunk,
    output logic       rBallSunk,
    output logic       ballsCollide,
    output logic       wBorderHit,
    output logic       rBorderHit,
    output logic [3:0] score
);

    // Counters only ever hold (frames - 1), so log2 of the larger count is enough.
    localparam int MAX_FRAMES = (BLINK_FRAMES > RESPAWN_FRAMES) ? BLINK_FRAMES : RESPAWN_FRAMES;
    localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
    localparam logic [CNT_W-1:0] BLINK_LOAD   = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] RESPAWN_LOAD = CNT_W'(RESPAWN_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_BLINK  = 2'd1,
        ST_HIDDEN = 2'd2
    } ball_state_t;

    ball_state_t      r_w_state;
    ball_state_t      r_r_state;
    logic [CNT_W-1:0] r_w_cnt;
    logic [CNT_W-1:0] r_r_cnt;
    logic             r_w_en;
    logic             r_r_en;

    // Flags accumulated during the current frame
    logic r_flag_wh;
    logic r_flag_rh;
    logic r_flag_bb;
    logic r_flag_wb;
    logic r_flag_rb;

    // Set by the first startOfFrame after reset; that first frame is treated as empty
    logic r_armed;

    // Registered event pulses (the evaluation stage)
    logic r_wsunk;
    logic r_rsunk;
    logic r_collide;
    logic r_wborder;
    logic r_rborder;

    logic [3:0] r_score;

    logic       w_w_active;
    logic       w_r_active;
    logic       w_hit_wh;
    logic       w_hit_rh;
    logic       w_hit_bb;
    logic       w_hit_wb;
    logic       w_hit_rb;
    logic       w_eval;
    logic       w_ev_wsunk;
    logic       w_ev_rsunk;
    logic       w_ev_collide;
    logic       w_ev_wborder;
    logic       w_ev_rborder;
    logic [3:0] w_score_inc;
    logic [3:0] w_score_next;

    assign w_w_active = (r_w_state == ST_ACTIVE);
    assign w_r_active = (r_r_state == ST_ACTIVE);

    // Coincidences only count while the balls involved are in play
    assign w_hit_wh = drawingRequestWBall & drawingRequestHole    & w_w_active;
    assign w_hit_rh = drawingRequestRBall & drawingRequestHole    & w_r_active;
    assign w_hit_bb = drawingRequestWBall & drawingRequestRBall   & w_w_active & w_r_active;
    assign w_hit_wb = drawingRequestWBall & drawingRequestBorders & w_w_active;
    assign w_hit_rb = drawingRequestRBall & drawingRequestBorders & w_r_active;

    // Evaluation re-checks ball state: a flag raised on the cycle a ball got
    // pocketed must not fire once that ball has left ACTIVE.
    assign w_eval       = startOfFrame & r_armed;
    assign w_ev_wsunk   = w_eval & r_flag_wh & w_w_active;
    assign w_ev_rsunk   = w_eval & r_flag_rh & w_r_active;
    assign w_ev_collide = w_eval & r_flag_bb & w_w_active & w_r_active;
    assign w_ev_wborder = w_eval & r_flag_wb & w_w_active;
    assign w_ev_rborder = w_eval & r_flag_rb & w_r_active;

    // Increment (red pocketed) is applied before decrement (white foul), both saturating
    assign w_score_inc  = (w_ev_rsunk && (r_score != 4'd15)) ? (r_score + 4'd1) : r_score;
    assign w_score_next = (w_ev_wsunk && (w_score_inc != 4'd0)) ? (w_score_inc - 4'd1) : w_score_inc;

    // Frame flag accumulation; startOfFrame restarts them with that cycle's own coincidences
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_flag_wh <= 1'b0;
            r_flag_rh <= 1'b0;
            r_flag_bb <= 1'b0;
            r_flag_wb <= 1'b0;
            r_flag_rb <= 1'b0;
        end else if (startOfFrame) begin
            r_flag_wh <= w_hit_wh;
            r_flag_rh <= w_hit_rh;
            r_flag_bb <= w_hit_bb;
            r_flag_wb <= w_hit_wb;
            r_flag_rb <= w_hit_rb;
        end else begin
            r_flag_wh <= r_flag_wh | w_hit_wh;
            r_flag_rh <= r_flag_rh | w_hit_rh;
            r_flag_bb <= r_flag_bb | w_hit_bb;
            r_flag_wb <= r_flag_wb | w_hit_wb;
            r_flag_rb <= r_flag_rb | w_hit_rb;
        end
    end

    // Event pulses: one cycle wide, only in the cycle following startOfFrame
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_armed   <= 1'b0;
            r_wsunk   <= 1'b0;
            r_rsunk   <= 1'b0;
            r_collide <= 1'b0;
            r_wborder <= 1'b0;
            r_rborder <= 1'b0;
        end else begin
            if (startOfFrame) begin
                r_armed <= 1'b1;
            end
            r_wsunk   <= w_ev_wsunk;
            r_rsunk   <= w_ev_rsunk;
            r_collide <= w_ev_collide;
            r_wborder <= w_ev_wborder;
            r_rborder <= w_ev_rborder;
        end
    end

    // Score register, changes together with the sunk pulses
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_score <= 4'd0;
        end else begin
            r_score <= w_score_next;
        end
    end

    // White ball sequencer: ACTIVE -> BLINK -> HIDDEN -> ACTIVE, advanced per frame
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_w_state <= ST_ACTIVE;
            r_w_cnt   <= '0;
            r_w_en    <= 1'b1;
        end else if (startOfFrame) begin
            case (r_w_state)
                ST_ACTIVE: begin
                    r_w_en <= 1'b1;
                    if (w_ev_wsunk) begin
                        r_w_state <= ST_BLINK;
                        r_w_cnt   <= BLINK_LOAD;
                        r_w_en    <= 1'b0;
                    end
                end
                ST_BLINK: begin
                    if (r_w_cnt == '0) begin
                        r_w_state <= ST_HIDDEN;
                        r_w_cnt   <= RESPAWN_LOAD;
                        r_w_en    <= 1'b0;
                    end else begin
                        r_w_cnt <= r_w_cnt - 1'b1;
                        r_w_en  <= ~r_w_en;
                    end
                end
                ST_HIDDEN: begin
                    if (r_w_cnt == '0) begin
                        r_w_state <= ST_ACTIVE;
                        r_w_en    <= 1'b1;
                    end else begin
                        r_w_cnt <= r_w_cnt - 1'b1;
                        r_w_en  <= 1'b0;
                    end
                end
                default: begin
                    r_w_state <= ST_ACTIVE;
                    r_w_cnt   <= '0;
                    r_w_en    <= 1'b1;
                end
            endcase
        end
    end

    // Red ball sequencer: same behaviour as the white one, driven by the red sunk event
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_r_state <= ST_ACTIVE;
            r_r_cnt   <= '0;
            r_r_en    <= 1'b1;
        end else if (startOfFrame) begin
            case (r_r_state)
                ST_ACTIVE: begin
                    r_r_en <= 1'b1;
                    if (w_ev_rsunk) begin
                        r_r_state <= ST_BLINK;
                        r_r_cnt   <= BLINK_LOAD;
                        r_r_en    <= 1'b0;
                    end
                end
                ST_BLINK: begin
                    if (r_r_cnt == '0) begin
                        r_r_state <= ST_HIDDEN;
                        r_r_cnt   <= RESPAWN_LOAD;
                        r_r_en    <= 1'b0;
                    end else begin
                        r_r_cnt <= r_r_cnt - 1'b1;
                        r_r_en  <= ~r_r_en;
                    end
                end
                ST_HIDDEN: begin
                    if (r_r_cnt == '0) begin
                        r_r_state <= ST_ACTIVE;
                        r_r_en    <= 1'b1;
                    end else begin
                        r_r_cnt <= r_r_cnt - 1'b1;
                        r_r_en  <= 1'b0;
                    end
                end
                default: begin
                    r_r_state <= ST_ACTIVE;
                    r_r_cnt   <= '0;
                    r_r_en    <= 1'b1;
                end
            endcase
        end
    end

    assign wBallEnable  = r_w_en;
    assign rBallEnable  = r_r_en;
    assign wBallSunk    = r_wsunk;
    assign rBallSunk    = r_rsunk;
    assign ballsCollide = r_collide;
    assign wBorderHit   = r_wborder;
    assign rBorderHit   = r_rborder;
    assign score        = r_score;

endmodule

// File: tb/tb_frame_event_controller.sv
// Purpose : directed checks of frame_event_controller pulses, ball sequencing, score and reset.
// Latency : expectations queued when each startOfFrame is driven, popped one cycle later.
// Backpressure: none; every step is a fixed number of clock cycles.
module tb_frame_event_controller;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       drawingRequestHole;
    logic       drawingRequestWBall;
    logic       drawingRequestRBall;
    logic       drawingRequestBorders;
    logic       wBallEnable;
    logic       rBallEnable;
    logic       wBallSunk;
    logic       rBallSunk;
    logic       ballsCollide;
    logic       wBorderHit;
    logic       rBorderHit;
    logic [3:0] score;

    always #5 clk = ~clk;

    frame_event_controller #(
        .BLINK_FRAMES   (8),
        .RESPAWN_FRAMES (60)
    ) dut (
        .clk                   (clk),
        .resetN                (resetN),
        .startOfFrame          (startOfFrame),
        .drawingRequestHole    (drawingRequestHole),
        .drawingRequestWBall   (drawingRequestWBall),
        .drawingRequestRBall   (drawingRequestRBall),
        .drawingRequestBorders (drawingRequestBorders),
        .wBallEnable           (wBallEnable),
        .rBallEnable           (rBallEnable),
        .wBallSunk             (wBallSunk),
        .rBallSunk             (rBallSunk),
        .ballsCollide          (ballsCollide),
        .wBorderHit            (wBorderHit),
        .rBorderHit            (rBorderHit),
        .score                 (score)
    );

    // Pulse vector order: {wBallSunk, rBallSunk, ballsCollide, wBorderHit, rBorderHit}
    localparam logic [4:0] P_NONE = 5'b00000;
    localparam logic [4:0] P_WS   = 5'b10000;
    localparam logic [4:0] P_RS   = 5'b01000;
    localparam logic [4:0] P_BB   = 5'b00100;
    localparam logic [4:0] P_WB   = 5'b00010;
    localparam logic [4:0] P_RB   = 5'b00001;
    // Request order on the startOfFrame cycle: {WBall, RBall, Hole, Borders}
    localparam logic [3:0] RQ_NONE = 4'b0000;
    localparam logic [3:0] RQ_WR   = 4'b1100;

    typedef struct {
        logic [4:0] p;
        logic [3:0] s;
        logic       wen;
        logic       ren;
    } exp_t;

    exp_t sb[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   w_since   = 68;   // frames since white was pocketed (>=68 means in play)
    int   r_since   = 68;
    int   exp_score = 0;

    // Enable expected k frames after a pocket: blink 0,1,0,... for 8 frames, off for 60, then on
    function automatic logic en_model(input int k);
        if (k >= 68) return 1'b1;
        if (k < 8)   return ((k % 2) == 1);
        return 1'b0;
    endfunction

    function automatic logic [4:0] pulses();
        return {wBallSunk, rBallSunk, ballsCollide, wBorderHit, rBorderHit};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic h, input logic b);
        drawingRequestWBall   = w;
        drawingRequestRBall   = r;
        drawingRequestHole    = h;
        drawingRequestBorders = b;
    endtask

    // Hold a request combination for n cycles, then one idle cycle
    task automatic req(input logic w, input logic r, input logic h, input logic b, input int n);
        drive(w, r, h, b);
        repeat (n) cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
    endtask

    // Issue a startOfFrame (optionally with coincident requests) and check the following cycles
    task automatic sof(input logic [3:0] rq, input logic [4:0] ep, input logic [3:0] es, input string tag);
        exp_t e;
        exp_t got;
        drive(rq[3], rq[2], rq[1], rq[0]);
        startOfFrame = 1'b1;
        if (ep[4]) w_since = 0; else if (w_since < 68) w_since++;
        if (ep[3]) r_since = 0; else if (r_since < 68) r_since++;
        e.p   = ep;
        e.s   = es;
        e.wen = en_model(w_since);
        e.ren = en_model(r_since);
        sb.push_back(e);
        cyc();
        startOfFrame = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        got = sb.pop_front();
        chk({tag, ".pulse"}, {3'b000, pulses()}, {3'b000, got.p});
        chk({tag, ".score"}, {4'h0, score}, {4'h0, got.s});
        chk({tag, ".wen"}, {7'h00, wBallEnable}, {7'h00, got.wen});
        chk({tag, ".ren"}, {7'h00, rBallEnable}, {7'h00, got.ren});
        cyc();
        chk({tag, ".clr"}, {3'b000, pulses()}, {3'b000, P_NONE});
    endtask

    task automatic run_frames(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            sof(RQ_NONE, P_NONE, exp_score[3:0], tag);
        end
    endtask

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc();
        chk("rst.pulse", {3'b000, pulses()}, 8'h00);
        chk("rst.score", {4'h0, score}, 8'h00);
        chk("rst.wen", {7'h00, wBallEnable}, 8'h01);
        chk("rst.ren", {7'h00, rBallEnable}, 8'h01);
        resetN = 1'b1;
        cyc();

        // First frame after reset is evaluated as empty even with an overlap in it
        req(1'b1, 1'b1, 1'b0, 1'b0, 2);
        sof(RQ_NONE, P_NONE, 4'd0, "arm");
        sof(RQ_NONE, P_NONE, 4'd0, "empty");

        // White pocketed at score 0: foul saturates at 0
        req(1'b1, 1'b0, 1'b1, 1'b0, 2);
        sof(RQ_NONE, P_WS, 4'd0, "wpot0");

        // Red pocketed: score 0 -> 1, then blink/hide sequence
        req(1'b0, 1'b1, 1'b1, 1'b0, 3);
        exp_score = 1;
        sof(RQ_NONE, P_RS, 4'd1, "rpot1");
        run_frames(19, "rseq");

        // Red hidden: hole, border and overlap requests must produce nothing
        req(1'b1, 1'b1, 1'b0, 1'b0, 1);
        req(1'b0, 1'b1, 1'b1, 1'b0, 1);
        req(1'b0, 1'b1, 1'b0, 1'b1, 1);
        sof(RQ_NONE, P_NONE, 4'd1, "hidden");
        run_frames(48, "respawn");

        // Overlap for one frame only
        req(1'b1, 1'b1, 1'b0, 1'b0, 2);
        sof(RQ_NONE, P_BB, 4'd1, "collide");
        sof(RQ_NONE, P_NONE, 4'd1, "nocollide");

        // Both balls touch borders in the same frame
        req(1'b1, 1'b0, 1'b0, 1'b1, 1);
        req(1'b0, 1'b1, 1'b0, 1'b1, 1);
        sof(RQ_NONE, P_WB | P_RB, 4'd1, "borders");

        // Overlap only on the startOfFrame cycle belongs to the next frame
        sof(RQ_WR, P_NONE, 4'd1, "sofhit");
        sof(RQ_NONE, P_BB, 4'd1, "sofhit_next");

        // Drive score to 15 and one more to check upper saturation
        for (int i = 0; i < 15; i++) begin
            req(1'b0, 1'b1, 1'b1, 1'b0, 2);
            if (exp_score < 15) exp_score++;
            sof(RQ_NONE, P_RS, exp_score[3:0], "rpot");
            run_frames(68, "rcycle");
        end

        // Both pocketed at 15: increment saturates then decrement gives 14
        req(1'b1, 1'b0, 1'b1, 1'b0, 1);
        req(1'b0, 1'b1, 1'b1, 1'b0, 1);
        exp_score = 14;
        sof(RQ_NONE, P_WS | P_RS, 4'd14, "both15");
        run_frames(2, "blink");

        // Asynchronous reset mid-blink
        #2;
        resetN = 1'b0;
        #1;
        chk("arst.wen", {7'h00, wBallEnable}, 8'h01);
        chk("arst.ren", {7'h00, rBallEnable}, 8'h01);
        chk("arst.score", {4'h0, score}, 8'h00);
        chk("arst.pulse", {3'b000, pulses()}, 8'h00);
        cyc();
        resetN    = 1'b1;
        w_since   = 68;
        r_since   = 68;
        exp_score = 0;
        cyc();
        req(1'b0, 1'b1, 1'b1, 1'b0, 2);
        sof(RQ_NONE, P_NONE, 4'd0, "post_rst1");
        req(1'b0, 1'b1, 1'b1, 1'b0, 2);
        exp_score = 1;
        sof(RQ_NONE, P_RS, 4'd1, "post_rst2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
